// File: rtl/down_count_monitor.sv
// Transition checker for a 5-bit synchronous down counter.
// Flags illegal steps and emits zero/wrap pulses, a saturating wrap count and a threshold flag.
module down_count_monitor #(
    parameter int WIDTH  = 5,
    parameter int WRAP_W = 8,
    parameter int THRESH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              en_in,
    input  logic              set_in,
    input  logic              clr,
    output logic              zero_pulse,
    output logic              wrap_pulse,
    output logic              below_thr,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              step_err,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0]  ALL_ONES = '1;
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
    localparam logic [WIDTH:0]    THR      = THRESH[WIDTH:0];

    state_t           st;
    logic [WIDTH-1:0] prev_cnt;
    logic             en_q;
    logic             set_q;
    logic             step_ok;
    logic             zero_hit;
    logic             wrap_hit;

    assign state = st;

    // Controls registered with the previous sample decide what the current sample may be.
    // NOTE: every variable assigned in always_comb gets a default first, so no latch can form.
    always_comb begin
        step_ok  = 1'b0;
        zero_hit = 1'b0;
        wrap_hit = 1'b0;
        if (set_q) begin
            step_ok  = 1'b1;
            zero_hit = (cnt_in == '0);
        end else if (en_q) begin
            step_ok  = (cnt_in == prev_cnt - WIDTH'(1));
            zero_hit = step_ok && (cnt_in == '0);
            wrap_hit = step_ok && (prev_cnt == '0) && (cnt_in == ALL_ONES);
        end else begin
            step_ok  = (cnt_in == prev_cnt);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            prev_cnt   <= '0;
            en_q       <= 1'b0;
            set_q      <= 1'b0;
            zero_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            below_thr  <= 1'b0;
            wrap_cnt   <= '0;
            step_err   <= 1'b0;
        end else begin
            prev_cnt   <= cnt_in;
            en_q       <= en_in;
            set_q      <= set_in;
            below_thr  <= ({1'b0, cnt_in} < THR);
            zero_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            if (clr) begin
                wrap_cnt <= '0;
                step_err <= 1'b0;
                st       <= IDLE;
            end else begin
                unique case (st)
                    IDLE: begin
                        if (!set_in)
                            st <= TRACK;
                    end
                    TRACK: begin
                        if (!step_ok) begin
                            step_err <= 1'b1;
                            st       <= FAULT;
                        end else begin
                            zero_pulse <= zero_hit;
                            wrap_pulse <= wrap_hit;
                            if (wrap_hit && (wrap_cnt != WRAP_MAX))
                                wrap_cnt <= wrap_cnt + WRAP_W'(1);
                        end
                    end
                    FAULT: ;
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/down_count_monitor.md
Name: down_count_monitor

Overview:
- Downstream consumer of the 5-bit synchronous down counter. Samples the counter's output together with its set/en controls.
- Checks every transition for legality (hold, decrement by 1, or preset) and flags the first illegal step.
- Produces registered event pulses (zero, wrap), a saturating wrap counter and a threshold flag for control logic further down the chain.

Parameters:
- WIDTH, 5: width of the monitored count.
- WRAP_W, 8: width of the wrap-event counter.
- THRESH, 3: below_thr asserts when the sampled count < THRESH. Unsigned compare; legal range 0..2^WIDTH-1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cnt_in  in  WIDTH  count output of the upstream down counter.
- en_in  in  1  enable presented to the upstream counter, same cycle.
- set_in  in  1  preset presented to the upstream counter, same cycle.
- clr  in  1  synchronous clear of statistics and fault.
- zero_pulse  out  1  one-cycle pulse: count reached 0.
- wrap_pulse  out  1  one-cycle pulse: legal 0 -> all-ones wrap.
- below_thr  out  1  registered (cnt_in < THRESH).
- wrap_cnt  out  WRAP_W  number of wraps, saturating.
- step_err  out  1  sticky illegal-transition flag.
- state  out  2  FSM state: 00 IDLE, 01 TRACK, 10 FAULT.

Behaviour:
- Reset (async, rst=1): state=IDLE; zero_pulse=0; wrap_pulse=0; below_thr=0; wrap_cnt=0; step_err=0. Internal prev_cnt=0, en_q=0, set_q=0.
- Each rising edge registers prev_cnt<=cnt_in, en_q<=en_in, set_q<=set_in, in every state.
- Controls sampled at edge k-1 govern the count sampled at edge k, matching the counter's one-cycle latency.
- IDLE: no checks, no pulses. Goes to TRACK on the first edge where set_in=0; that sample seeds prev_cnt.
- TRACK: at each edge, the expected cnt_in is:
  - set_q=1: any value is accepted and resynchronises; no wrap_pulse.
  - set_q=0, en_q=1: expected = (prev_cnt - 1) mod 2^WIDTH.
  - set_q=0, en_q=0: expected = prev_cnt (hold).
- Mismatch in TRACK: step_err<=1 and state<=FAULT on that edge. No pulses are generated for that sample.
- Legal decrement with prev_cnt=0 and cnt_in=all-ones: wrap_pulse=1 for one cycle; wrap_cnt increments, saturating at 2^WRAP_W-1.
- zero_pulse: in TRACK, asserts for one cycle after an edge that samples cnt_in=0 via a legal step or resync.
  - A held 0 (en_q=0) produces no repeat pulse.
  - Latency is 1 clock from the sample.
- below_thr: updated every edge in every state from cnt_in, 1-cycle latency.
- FAULT: all checks and pulses suppressed; step_err and wrap_cnt held. Exit only via clr or rst.
- clr=1 (any state), at the next edge:
  - wrap_cnt=0, step_err=0, pulses=0, state=IDLE.
  - clr wins over a simultaneous wrap or mismatch.
  - below_thr is still updated.
- Reset mid-operation: outputs clear immediately, without waiting for clk. The first edge after release follows the IDLE rules.
- Arithmetic: the decrement is modulo 2^WIDTH; the compare is unsigned; the wrap counter never rolls over.

Test Plan:
- rst pulse, then set_in=1 for 1 cycle, then en_in=1 with the counter free-running from 11111 -> state=01. Across 32 decrements: exactly one zero_pulse (cycle after 00000) and one wrap_pulse (cycle after 11111 follows 00000); wrap_cnt=1; step_err=0.
- en_in toggled 1,0,0,1 with the counter at 00101 -> hold samples accepted; no step_err; below_thr goes 1 one cycle after cnt_in=00010.
- Force cnt_in to jump 01000 -> 00110 with en_q=1 -> step_err=1 and state=10 on that edge. Later legal wraps leave wrap_cnt unchanged.
- FAULT, then clr=1 for 1 cycle -> step_err=0, wrap_cnt=0, state=00. Next sample with set_in=0 -> state=01.
- Run 300 wraps with WRAP_W=8 -> wrap_cnt saturates at 255; wrap_pulse still pulses each wrap.
- Assert rst asynchronously mid-count (between edges) -> all outputs 0 before the next clk edge. clr asserted on the same edge as a wrap -> wrap_cnt=0, wrap_pulse=0.
